multicycle_ctrl: RTL



---
 rtl/multicycle_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack timeout.
// Optional macro SINGLE_STEP_EN adds a step input and PAUSE state. Rev 1.0
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_W     = 16
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic               start,
`ifdef SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [2:0]         instr_op,
  input  logic               dec_registerwrite,
  input  logic               dec_memw,
  input  logic               dec_mem2reg,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               alu_en,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               rf_we,
  output logic               busy,
  output logic               halted,
  output logic               err,
`ifdef SINGLE_STEP_EN
  output logic [3:0]         state,
`else
  output logic [2:0]         state,
`endif
  output logic [COUNT_W-1:0] instr_count
);

`ifdef SINGLE_STEP_EN
  localparam int SW = 4;
`else
  localparam int SW = 3;
`endif

  // Wide enough to hold MEM_TIMEOUT-1 even when MEM_TIMEOUT is 1.
  localparam int           TW     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [SW-1:0] {
    S_IDLE   = SW'(0),
    S_FETCH  = SW'(1),
    S_DECODE = SW'(2),
    S_EXEC   = SW'(3),
    S_MEM    = SW'(4),
    S_WB     = SW'(5),
    S_HALT   = SW'(6),
`ifdef SINGLE_STEP_EN
    S_ERR    = SW'(7),
    S_PAUSE  = SW'(8)
`else
    S_ERR    = SW'(7)
`endif
  } state_t;

`ifdef SINGLE_STEP_EN
  localparam state_t S_RETIRE = S_PAUSE;
`else
  localparam state_t S_RETIRE = S_FETCH;
`endif

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
    end
  end

  // Timer only survives a FETCH/MEM cycle without ack, so it is zero on entry.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    count_d = count_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack)               state_d = S_DECODE;
        else if (timer_q == T_LAST) state_d = S_ERR;
        else                        timer_d = timer_q + TW'(1);
      end
      S_DECODE: begin
        case (instr_op)
          3'b001:  state_d = S_HALT;
          3'b000: begin
            state_d = S_RETIRE;
            count_d = count_q + COUNT_W'(1);
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: state_d = (dec_memw || dec_mem2reg) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          if (dec_memw) begin
            state_d = S_RETIRE;
            count_d = count_q + COUNT_W'(1);
          end else begin
            state_d = S_WB;
          end
        end else if (timer_q == T_LAST) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WB: begin
        state_d = S_RETIRE;
        count_d = count_q + COUNT_W'(1);
      end
`ifdef SINGLE_STEP_EN
      S_PAUSE: if (step) state_d = S_FETCH;
`endif
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  assign imem_req    = (state_q == S_FETCH);
  assign ir_load     = (state_q == S_FETCH) && imem_ack;
  assign pc_inc      = (state_q == S_FETCH) && imem_ack;
  assign alu_en      = (state_q == S_EXEC);
  assign dmem_req    = (state_q == S_MEM);
  assign dmem_we     = (state_q == S_MEM) && dec_memw;
  assign rf_we       = (state_q == S_WB) && dec_registerwrite;
`ifdef SINGLE_STEP_EN
  assign busy        = ((state_q >= S_FETCH) && (state_q <= S_WB)) || (state_q == S_PAUSE);
`else
  assign busy        = (state_q >= S_FETCH) && (state_q <= S_WB);
`endif
  assign halted      = (state_q == S_HALT);
  assign err         = (state_q == S_ERR);
  assign state       = state_q;
  assign instr_count = count_q;

endmodule
`default_nettype wire
